// File: rtl/seq_eqcmp.sv
// seq_eqcmp: multi-cycle lane-wise equality comparator.
//
// Compares two packed vectors of LANES elements (WIDTH bits each), one lane
// per clock, so wide operands need only a single WIDTH-bit comparator.
// A start in IDLE latches both operands, then RUN walks lanes 0..LANES-1
// (always LANES cycles, no early exit), then DONE pulses done for one cycle.
//
// Ports:
//   clk      in   system clock, rising edge
//   reset    in   synchronous active-high reset
//   start    in   compare request, sampled only in IDLE
//   a, b     in   operands, lane i = x[i*WIDTH +: WIDTH]
//   busy     out  high while lanes are being compared
//   done     out  one-cycle pulse, results valid
//   eq       out  all lanes equal
//   mask     out  bit i set when lane i is equal
//   first_ne out  lowest mismatching lane index, 0 when eq=1
module seq_eqcmp #(
   parameter  int unsigned WIDTH = 8,
   parameter  int unsigned LANES = 4,
   localparam int unsigned IDXW  = $clog2(LANES)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic [WIDTH*LANES-1:0]   a,
   input  logic [WIDTH*LANES-1:0]   b,
   output logic                     busy,
   output logic                     done,
   output logic                     eq,
   output logic [LANES-1:0]         mask,
   output logic [IDXW-1:0]          first_ne
);

   localparam logic [IDXW-1:0] LastLane = IDXW'(LANES - 1);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e                        state_q;
   logic [LANES-1:0][WIDTH-1:0]   a_q;
   logic [LANES-1:0][WIDTH-1:0]   b_q;
   logic [IDXW-1:0]               cnt_q;
   logic                          found_q;
   logic                          busy_q;
   logic                          done_q;
   logic                          eq_q;
   logic [LANES-1:0]              mask_q;
   logic [IDXW-1:0]               first_ne_q;
   logic                          lane_eq;

   // Single shared comparator, steered by the lane counter.
   assign lane_eq = (a_q[cnt_q] == b_q[cnt_q]);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= StIdle;
         a_q        <= '0;
         b_q        <= '0;
         cnt_q      <= '0;
         found_q    <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         eq_q       <= 1'b0;
         mask_q     <= '0;
         first_ne_q <= '0;
      end else begin
         case (state_q)
            StIdle: begin
               if (start) begin
                  a_q        <= a;
                  b_q        <= b;
                  mask_q     <= '0;
                  first_ne_q <= '0;
                  found_q    <= 1'b0;
                  cnt_q      <= '0;
                  busy_q     <= 1'b1;
                  state_q    <= StRun;
               end
            end
            StRun: begin
               mask_q[cnt_q] <= lane_eq;
               // Only the first mismatch is recorded.
               if (!lane_eq && !found_q) begin
                  first_ne_q <= cnt_q;
                  found_q    <= 1'b1;
               end
               if (cnt_q == LastLane) begin
                  // Include the lane being compared on this edge.
                  eq_q    <= lane_eq & ~found_q;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= StDone;
               end else begin
                  cnt_q <= cnt_q + IDXW'(1);
               end
            end
            StDone: begin
               done_q  <= 1'b0;
               state_q <= StIdle;
            end
            default: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign eq       = eq_q;
   assign mask     = mask_q;
   assign first_ne = first_ne_q;

endmodule

// File: tb/tb_seq_eqcmp.sv
// Directed self-checking bench for seq_eqcmp with WIDTH=8, LANES=4.
module tb_seq_eqcmp;

   logic        clk;
   logic        reset;
   logic        start;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic        done;
   logic        eq;
   logic [3:0]  mask;
   logic [1:0]  first_ne;

   int n_checks = 0;
   int n_pass   = 0;

   seq_eqcmp #(
      .WIDTH (8),
      .LANES (4)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .a        (a),
      .b        (b),
      .busy     (busy),
      .done     (done),
      .eq       (eq),
      .mask     (mask),
      .first_ne (first_ne)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      else n_pass++;
   endtask

   // Advance one edge and settle past it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_zero(input string tag);
      check({tag, ".busy"},     32'(busy),     32'd0);
      check({tag, ".done"},     32'(done),     32'd0);
      check({tag, ".eq"},       32'(eq),       32'd0);
      check({tag, ".mask"},     32'(mask),     32'd0);
      check({tag, ".first_ne"}, 32'(first_ne), 32'd0);
   endtask

   // Issue one compare, scramble operands after acceptance, then check
   // busy length, done timing and the results captured at the done pulse.
   task automatic run_cmp(input string name, input logic [31:0] va, input logic [31:0] vb,
                          input logic [3:0] emask, input logic [1:0] efirst, input logic eeq);
      int          nbusy;
      int          ndone;
      int          didx;
      logic        g_eq;
      logic [3:0]  g_mask;
      logic [1:0]  g_first;
      a = va;
      b = vb;
      start = 1'b1;
      step();
      start = 1'b0;
      a = ~va;
      b = vb ^ 32'h5a5a_5a5a;
      nbusy = 0;
      ndone = 0;
      didx  = -1;
      g_eq = 1'b0; g_mask = '0; g_first = '0;
      for (int i = 0; i < 10; i++) begin
         if (busy) nbusy++;
         if (done) begin
            ndone++;
            didx    = i;
            g_eq    = eq;
            g_mask  = mask;
            g_first = first_ne;
         end
         step();
      end
      check({name, ".busy_cycles"}, 32'(nbusy), 32'd4);
      check({name, ".done_count"},  32'(ndone), 32'd1);
      check({name, ".done_cycle"},  32'(didx),  32'd4);
      check({name, ".eq"},          32'(g_eq),    32'(eeq));
      check({name, ".mask"},        32'(g_mask),  32'(emask));
      check({name, ".first_ne"},    32'(g_first), 32'(efirst));
   endtask

   initial begin
      int d0;
      int d1;
      int nd;
      logic eq0;
      logic eq1;
      logic [3:0] m0;

      reset = 1'b1;
      start = 1'b0;
      a = '0;
      b = '0;

      // Reset then idle.
      for (int i = 0; i < 2; i++) begin
         step();
         check_zero("reset");
      end
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         check_zero("idle");
      end

      // All lanes equal, then results must hold.
      run_cmp("all_eq", 32'h1122_3344, 32'h1122_3344, 4'b1111, 2'd0, 1'b1);
      for (int i = 0; i < 10; i++) begin
         step();
         check("hold.eq",       32'(eq),       32'd1);
         check("hold.mask",     32'(mask),     32'hF);
         check("hold.first_ne", 32'(first_ne), 32'd0);
         check("hold.done",     32'(done),     32'd0);
      end

      // Lanes 0 and 2 mismatch; lane 0 must stay the reported one.
      run_cmp("multi_ne", 32'hAABB_CCDD, 32'hAA00_CC00, 4'b1010, 2'd0, 1'b0);

      // Only the top lane mismatches.
      run_cmp("high_ne", 32'h0102_0304, 32'hFF02_0304, 4'b0111, 2'd3, 1'b0);

      // Start held 12 cycles: accepted at cycle 0 and 6, done at 4 and 10.
      a = 32'h5555_AAAA;
      b = 32'h5555_AAAA;
      start = 1'b1;
      step();
      nd = 0; d0 = -1; d1 = -1;
      eq0 = 1'b0; eq1 = 1'b0; m0 = '0;
      for (int i = 0; i < 20; i++) begin
         if (done) begin
            if (nd == 0) begin
               d0 = i; eq0 = eq; m0 = mask;
            end else begin
               d1 = i; eq1 = eq;
            end
            nd++;
         end
         if (i == 1) a = 32'h1234_5678;
         if (i == 4) a = 32'h5555_AAAA;
         if (i == 7) a = 32'h0000_0000;
         if (i == 11) start = 1'b0;
         step();
      end
      check("held.done_count", 32'(nd),  32'd2);
      check("held.done0",      32'(d0),  32'd4);
      check("held.done1",      32'(d1),  32'd10);
      check("held.eq0",        32'(eq0), 32'd1);
      check("held.mask0",      32'(m0),  32'hF);
      check("held.eq1",        32'(eq1), 32'd1);

      // Reset during the second RUN cycle aborts with no done pulse.
      a = 32'h0000_0001;
      b = 32'h0000_0000;
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      check("abort.busy_before", 32'(busy), 32'd1);
      reset = 1'b1;
      step();
      check_zero("abort");
      reset = 1'b0;
      nd = 0;
      for (int i = 0; i < 8; i++) begin
         step();
         if (done) nd++;
      end
      check("abort.no_done", 32'(nd), 32'd0);
      check("abort.busy",    32'(busy), 32'd0);

      // Fresh compare after the abort.
      run_cmp("after_abort", 32'h1020_3040, 32'h10FF_3040, 4'b1011, 2'd2, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
